// File: rtl/blade_ignition_ctrl.sv
// Blade ignition sequencer: steps the lit length up/down every STEP_DIV cycles, latches blade config at ignition.
// Latency: state change one edge after a request, one length step per STEP_DIV cycles; no backpressure, requests are one-cycle pulses.
module blade_ignition_ctrl #(
  parameter int STEP_DIV = 4,
  parameter int MAX_LEN  = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] Config,
  input  logic       Ignite,
  input  logic       Retract,
  output logic [3:0] Len,
  output logic [1:0] State,
  output logic       Busy,
  output logic       Double,
  output logic       Flicker,
  output logic [1:0] CfgLatched
);

  typedef enum logic [1:0] {
    S_OFF     = 2'b00,
    S_EXTEND  = 2'b01,
    S_ON      = 2'b10,
    S_RETRACT = 2'b11
  } state_t;

  localparam logic [7:0] PRE_TC  = 8'(STEP_DIV - 1);
  localparam logic [3:0] LEN_MAX = 4'(MAX_LEN);

  state_t     state;
  logic [7:0] presc;
  logic [3:0] lfsr;
  logic       tc;

  assign tc     = (presc == PRE_TC);
  assign State  = state;
  assign Busy   = (state == S_EXTEND) || (state == S_RETRACT);
  assign Double = (CfgLatched == 2'b01) && (state != S_OFF);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_OFF;
      Len        <= 4'd0;
      presc      <= 8'd0;
      CfgLatched <= 2'b00;
      Flicker    <= 1'b0;
      lfsr       <= 4'b1001;
    end else begin
      lfsr    <= {lfsr[2:0], lfsr[3] ^ lfsr[2]};
      Flicker <= (state == S_ON && CfgLatched == 2'b11) ? lfsr[0] : 1'b0;
      case (state)
        S_OFF: begin
          if (Ignite && !Retract) begin
            state      <= S_EXTEND;
            CfgLatched <= Config;
            presc      <= 8'd0;
          end
        end
        S_EXTEND: begin
          if (Retract) begin
            state <= S_RETRACT;
            presc <= 8'd0;
          end else if (tc) begin
            presc <= 8'd0;
            // Saturating step: the edge that reaches full length also enters ON.
            if (Len >= LEN_MAX - 4'd1) begin
              Len   <= LEN_MAX;
              state <= S_ON;
            end else begin
              Len <= Len + 4'd1;
            end
          end else begin
            presc <= presc + 8'd1;
          end
        end
        S_ON: begin
          Len <= LEN_MAX;
          if (Retract) begin
            state <= S_RETRACT;
            presc <= 8'd0;
          end
        end
        S_RETRACT: begin
          if (Ignite && !Retract) begin
            state      <= S_EXTEND;
            CfgLatched <= Config;
            presc      <= 8'd0;
          end else if (tc) begin
            presc <= 8'd0;
            // A retract started at length 0 simply lands in OFF without wrapping.
            if (Len <= 4'd1) begin
              Len   <= 4'd0;
              state <= S_OFF;
            end else begin
              Len <= Len - 4'd1;
            end
          end else begin
            presc <= presc + 8'd1;
          end
        end
        default: state <= S_OFF;
      endcase
    end
  end

endmodule

// File: tb/tb_blade_ignition_ctrl.sv
// Directed bench for blade_ignition_ctrl at STEP_DIV=4, MAX_LEN=15 with hand-computed expectations.
module tb_blade_ignition_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] cfg;
  logic       ignite;
  logic       retract;
  logic [3:0] len;
  logic [1:0] state;
  logic       busy;
  logic       dbl;
  logic       flicker;
  logic [1:0] cfg_latched;

  int errors = 0;
  int checks = 0;
  int n      = 0;

  // LFSR contents after k edges since reset, starting from seed 1001.
  logic [3:0] lfsr_tbl [15] = '{4'h9, 4'h3, 4'h6, 4'hD, 4'hA, 4'h5, 4'hB, 4'h7,
                                4'hF, 4'hE, 4'hC, 4'h8, 4'h1, 4'h2, 4'h4};
  logic [3:0] tbl_val;

  always #5 clk = ~clk;

  blade_ignition_ctrl #(.STEP_DIV(4), .MAX_LEN(15)) dut (
    .clk        (clk),
    .rst        (rst),
    .Config     (cfg),
    .Ignite     (ignite),
    .Retract    (retract),
    .Len        (len),
    .State      (state),
    .Busy       (busy),
    .Double     (dbl),
    .Flicker    (flicker),
    .CfgLatched (cfg_latched)
  );

  task automatic steps(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    ignite  = 1'b0;
    retract = 1'b0;
    steps(2);
    n   = 0;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cfg = 2'b00; ignite = 1'b0; retract = 1'b0;
    steps(3);
    n   = 0;
    rst = 1'b0;
    chk("rst_len", 8'(len), 8'd0);
    chk("rst_state", 8'(state), 8'd0);
    chk("rst_busy", 8'(busy), 8'd0);
    chk("rst_double", 8'(dbl), 8'd0);
    chk("rst_flicker", 8'(flicker), 8'd0);
    chk("rst_cfg", 8'(cfg_latched), 8'd0);

    // Full ignition with double config; config then changes while extending.
    cfg = 2'b01; ignite = 1'b1;
    steps(1);
    ignite = 1'b0; cfg = 2'b10;
    chk("ign_state", 8'(state), 8'd1);
    chk("ign_cfg", 8'(cfg_latched), 8'd1);
    chk("ign_double", 8'(dbl), 8'd1);
    chk("ign_busy", 8'(busy), 8'd1);
    chk("ign_len0", 8'(len), 8'd0);
    steps(3);
    chk("ext_len_e3", 8'(len), 8'd0);
    steps(1);
    chk("ext_len_e4", 8'(len), 8'd1);
    steps(55);
    chk("ext_len_e59", 8'(len), 8'd14);
    chk("ext_state_e59", 8'(state), 8'd1);
    steps(1);
    chk("on_len", 8'(len), 8'd15);
    chk("on_state", 8'(state), 8'd2);
    chk("on_busy", 8'(busy), 8'd0);
    chk("on_cfg_kept", 8'(cfg_latched), 8'd1);
    chk("on_double", 8'(dbl), 8'd1);

    ignite = 1'b1;
    steps(1);
    ignite = 1'b0;
    chk("on_ignite_ignored", 8'(state), 8'd2);
    chk("on_len_hold", 8'(len), 8'd15);

    // Full retraction from ON.
    retract = 1'b1;
    steps(1);
    retract = 1'b0;
    chk("ret_state", 8'(state), 8'd3);
    chk("ret_len15", 8'(len), 8'd15);
    chk("ret_busy", 8'(busy), 8'd1);
    steps(3);
    chk("ret_len_r3", 8'(len), 8'd15);
    steps(1);
    chk("ret_len_r4", 8'(len), 8'd14);
    steps(55);
    chk("ret_len_r59", 8'(len), 8'd1);
    chk("ret_state_r59", 8'(state), 8'd3);
    steps(1);
    chk("off_len", 8'(len), 8'd0);
    chk("off_state", 8'(state), 8'd0);
    chk("off_busy", 8'(busy), 8'd0);
    chk("off_double", 8'(dbl), 8'd0);

    // Both requests in OFF: retract wins, nothing happens.
    ignite = 1'b1; retract = 1'b1;
    steps(1);
    ignite = 1'b0; retract = 1'b0;
    chk("off_both_state", 8'(state), 8'd0);

    // Interrupted extend, then re-ignite mid-retract with a new config.
    cfg = 2'b01; ignite = 1'b1;
    steps(1);
    ignite = 1'b0;
    steps(28);
    chk("mid_len7", 8'(len), 8'd7);
    chk("mid_state_ext", 8'(state), 8'd1);
    retract = 1'b1;
    steps(1);
    retract = 1'b0;
    chk("mid_ret_state", 8'(state), 8'd3);
    chk("mid_ret_len7", 8'(len), 8'd7);
    steps(4);
    chk("mid_ret_len6", 8'(len), 8'd6);
    steps(4);
    chk("mid_ret_len5", 8'(len), 8'd5);
    cfg = 2'b10; ignite = 1'b1;
    steps(1);
    ignite = 1'b0;
    chk("reign_state", 8'(state), 8'd1);
    chk("reign_len5", 8'(len), 8'd5);
    chk("reign_cfg", 8'(cfg_latched), 8'd2);
    chk("reign_double", 8'(dbl), 8'd0);
    steps(4);
    chk("reign_len6", 8'(len), 8'd6);
    steps(36);
    chk("reign_on_state", 8'(state), 8'd2);
    chk("reign_on_len", 8'(len), 8'd15);
    ignite = 1'b1; retract = 1'b1;
    steps(1);
    ignite = 1'b0; retract = 1'b0;
    chk("on_both_state", 8'(state), 8'd3);
    chk("on_both_len", 8'(len), 8'd15);

    // Unstable blade: flicker tracks the LFSR while ON, config changes ignored.
    do_reset();
    cfg = 2'b11; ignite = 1'b1;
    steps(1);
    ignite = 1'b0;
    steps(59);
    chk("uns_state_ext", 8'(state), 8'd1);
    steps(1);
    chk("uns_state_on", 8'(state), 8'd2);
    chk("uns_flicker_first", 8'(flicker), 8'd0);
    cfg = 2'b00;
    for (int i = 0; i < 16; i++) begin
      steps(1);
      tbl_val = lfsr_tbl[(n - 1) % 15];
      chk("uns_flicker", 8'(flicker), 8'(tbl_val[0]));
    end
    chk("uns_cfg_kept", 8'(cfg_latched), 8'd3);
    retract = 1'b1;
    steps(1);
    retract = 1'b0;
    tbl_val = lfsr_tbl[(n - 1) % 15];
    chk("uns_flicker_ret0", 8'(flicker), 8'(tbl_val[0]));
    steps(1);
    chk("uns_flicker_ret1", 8'(flicker), 8'd0);

    // Reset mid-extend with ignite held high.
    do_reset();
    cfg = 2'b01; ignite = 1'b1;
    steps(1);
    ignite = 1'b0;
    steps(36);
    chk("pre_rst_len9", 8'(len), 8'd9);
    rst = 1'b1; ignite = 1'b1;
    steps(1);
    chk("mrst_len", 8'(len), 8'd0);
    chk("mrst_state", 8'(state), 8'd0);
    chk("mrst_flicker", 8'(flicker), 8'd0);
    chk("mrst_cfg", 8'(cfg_latched), 8'd0);
    chk("mrst_busy", 8'(busy), 8'd0);
    steps(1);
    chk("mrst_hold_state", 8'(state), 8'd0);
    rst = 1'b0; ignite = 1'b0;
    steps(1);
    chk("post_rst_state", 8'(state), 8'd0);
    chk("post_rst_len", 8'(len), 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
